nn_mem_arbiter: RTL and testbench
=================================

// Module: nn_mem_arbiter
// PURPOSE
//  Shares the NETWORK_RAM / TRAINER_RAM port bus (ena, wr_ena, addr, wr_data) between two requesters:
//  0 = forward-propagation engine, 1 = back-propagation engine.
//  Round-robin arbitration with burst locking, read-return routing and lock-timeout recovery.
//  Sits between the training-loop FSM's engines and the two bram instances in neural_network_top.
// PARAMETERS
//  ADDR_LEN      5   address width shared by both RAMs (trainer RAM ignores upper bits)
//  DATA_LEN      32  word width of both RAMs
//  LOCK_TIMEOUT  16  idle cycles a locked owner may go without req before the lock is force-released
// PORTS
//  clk_i              in   1            clock
//  reset_i            in   1            asynchronous reset, active-high
//  req_i              in   2            per-requester beat request; held with payload until granted
//  we_i               in   2            1 = write beat, 0 = read beat
//  sel_i              in   2            target RAM: 0 = network RAM, 1 = trainer RAM
//  last_i             in   2            beat ends the requester's burst (releases lock)
//  addr_i             in   2*ADDR_LEN   per-requester address, requester i at [i*ADDR_LEN +: ADDR_LEN]
//  wdata_i            in   2*DATA_LEN   per-requester write data, same packing
//  gnt_o              out  2            combinational; beat accepted in any cycle where req_i[i] & gnt_o[i]
//  rvalid_o           out  2            1-cycle pulse: read data for requester i is on rdata_o
//  rdata_o            out  DATA_LEN     returned read word
//  lock_err_o         out  1            1-cycle pulse when a lock is force-released by timeout
//  network_ena_o      out  1            network RAM enable
//  trainer_ena_o      out  1            trainer RAM enable
//  wr_ena_o           out  1            write enable, shared by both RAMs
//  addr_o             out  ADDR_LEN     shared RAM address
//  wr_data_o          out  DATA_LEN     shared RAM write data
//  network_rd_data_i  in   DATA_LEN     network RAM data_o (valid 1 cycle after ena)
//  trainer_rd_data_i  in   DATA_LEN     trainer RAM data_o (valid 1 cycle after ena)
// BEHAVIOUR
//  Reset
//   - All outputs 0; state ARB_IDLE; rr pointer last_owner = 1, so requester 0 wins the first tie.
//   - Read pipeline cleared; in-flight reads are dropped, no rvalid issued.
//  Arbitration (gnt_o combinational, at most one bit set)
//   - ARB_IDLE: grant the sole requester. If both request, grant the one != last_owner.
//     On accept, last_owner := winner.
//   - ARB_LOCKn: only requester n can be granted; the other is stalled.
//  State machine
//   - ARB_IDLE -> ARB_LOCKn: accepted beat from n with last_i[n]=0.
//   - ARB_IDLE -> ARB_IDLE: accepted beat with last_i=1 (single-beat burst).
//   - ARB_LOCKn -> ARB_IDLE: accepted beat from n with last_i[n]=1.
//   - ARB_LOCKn -> ARB_IDLE: idle counter reaches LOCK_TIMEOUT; also pulses lock_err_o.
//     Idle counter: cycles in ARB_LOCKn with req_i[n]=0; reset on every accepted beat.
//     Counter width is $clog2(LOCK_TIMEOUT+1) and it saturates.
//  Memory issue (registered)
//   - Beat accepted in cycle N drives the memory ports in cycle N+1:
//     ena of selected RAM = 1, wr_ena_o = we, addr_o / wr_data_o = payload.
//   - No accept in N: both ena = 0 and wr_ena_o = 0 in N+1; addr_o / wr_data_o hold their last value.
//   - Throughput: one beat per cycle, back-to-back, including across an owner change.
//  Read return
//   - Read accepted in N: rvalid_o[owner] = 1 in N+2.
//     rdata_o = network_rd_data_i or trainer_rd_data_i, selected by the sel delayed 2 cycles.
//   - Writes never produce rvalid. rdata_o holds its last value when rvalid_o = 0.
//   - Read-after-write to the same address in consecutive beats returns the new data (RAM write-first).
//  Boundaries
//   - Owner drops req mid-burst: lock is kept until last_i or timeout.
//   - A req arriving in the same cycle as a lock release is not granted until the next cycle
//     (state is registered).
//   - LOCK_TIMEOUT fires in the same cycle the owner re-asserts req: the beat is granted,
//     the counter clears, no error is raised.
//   - addr wraps naturally at 2^ADDR_LEN; no range check.
// STRUCTURE
//  Package nn_mem_pkg:
//   - arb_state_t {ARB_IDLE, ARB_LOCK0, ARB_LOCK1}
//   - mem_sel_t {SEL_NETWORK = 0, SEL_TRAINER = 1}
//   - struct mem_beat_t {we, sel, last, addr, wdata}
//  Sub-module nn_mem_rd_pipe: 2-stage {valid, owner, sel} shift register plus the rdata mux.
// TESTING
//  1. Reset, then req0 read sel=0 addr=3 last=1 -> gnt0 same cycle; network_ena_o=1, addr_o=3 next cycle;
//     rvalid_o=2'b01 two cycles after accept, rdata_o = network mem[3].
//  2. req0 and req1 both asserted, single beats, held 4 cycles -> grants alternate 0,1,0,1;
//     every cycle has exactly one RAM ena.
//  3. req0 4-beat write burst (last on beat 4) with req1 asserted throughout -> gnt1 stays 0
//     until beat 4 is accepted, then gnt1 on the next cycle.
//  4. req0 write sel=1 addr=2 data=32'hDEAD_BEEF, then req0 read sel=1 addr=2 ->
//     trainer_ena_o on both beats, wr_ena_o=1 then 0; rdata_o=32'hDEAD_BEEF, rvalid_o[0].
//  5. req1 one beat with last=0, then req deasserted 16 cycles -> lock_err_o pulses once;
//     back to ARB_IDLE; pending req0 granted the following cycle.
//  6. Assert reset_i one cycle after a read accept -> all outputs 0 asynchronously; no rvalid after release.

Source files
------------

// File: rtl/nn_mem_pkg.sv
// Shared types for the NN memory arbiter: arbiter states, RAM select, beat payload.
// No logic; widths of the beat payload track the default RAM geometry.
// Top-level ADDR_LEN / DATA_LEN must stay equal to NN_ADDR_LEN / NN_DATA_LEN.
package nn_mem_pkg;

    localparam int NN_ADDR_LEN = 5;
    localparam int NN_DATA_LEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        SEL_NETWORK = 1'b0,
        SEL_TRAINER = 1'b1
    } mem_sel_t;

    typedef struct packed {
        logic                   we;
        mem_sel_t               sel;
        logic                   last;
        logic [NN_ADDR_LEN-1:0] addr;
        logic [NN_DATA_LEN-1:0] wdata;
    } mem_beat_t;

    function automatic arb_state_t lock_state(input logic owner);
        return owner ? ARB_LOCK1 : ARB_LOCK0;
    endfunction

endpackage

// File: rtl/nn_mem_rd_pipe.sv
// Read-return pipeline: tracks {valid, owner, sel} of issued reads for two cycles and muxes RAM data.
// Latency: read issued (accepted) in N -> rvalid/rdata in N+2. rdata holds between returns.
// Backpressure: none; requesters must always sink a returned word.
// Ports: issue/owner/sel of the accepted read, both RAM data outputs, per-requester rvalid and rdata.
module nn_mem_rd_pipe
    import nn_mem_pkg::*;
#(
    parameter int DATA_LEN = NN_DATA_LEN
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                issue_i,
    input  logic                owner_i,
    input  mem_sel_t            sel_i,
    input  logic [DATA_LEN-1:0] network_rd_data_i,
    input  logic [DATA_LEN-1:0] trainer_rd_data_i,
    output logic [1:0]          rvalid_o,
    output logic [DATA_LEN-1:0] rdata_o
);

    typedef struct packed {
        logic     vld;
        logic     owner;
        mem_sel_t sel;
    } rd_tag_t;

    rd_tag_t             s1_q;
    rd_tag_t             s2_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic [DATA_LEN-1:0] rdata_mux;

    // RAM output is valid in the cycle after ena, i.e. while the tag sits in stage 2,
    // so the live RAM word is forwarded and only captured for the hold behaviour.
    assign rdata_mux = (s2_q.sel == SEL_TRAINER) ? trainer_rd_data_i : network_rd_data_i;
    assign rdata_o   = s2_q.vld ? rdata_mux : rdata_q;
    assign rvalid_o  = {s2_q.vld & s2_q.owner, s2_q.vld & ~s2_q.owner};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q    <= '0;
            s2_q    <= '0;
            rdata_q <= '0;
        end else begin
            s1_q <= '{vld: issue_i, owner: owner_i, sel: sel_i};
            s2_q <= s1_q;
            if (s2_q.vld) begin
                rdata_q <= rdata_mux;
            end
        end
    end

endmodule

// File: rtl/nn_mem_arbiter.sv
// Two-requester (0 = forward, 1 = backprop) arbiter for the network/trainer RAM port bus.
// Latency: gnt combinational; RAM ports driven the cycle after accept; read data 2 cycles after accept.
// Backpressure: requester holds req+payload until gnt; the loser (or non-owner during a burst) stalls.
// Ports: req/we/sel/last/addr/wdata per requester in, gnt/rvalid/rdata/lock_err out,
//        shared RAM bus out (network_ena, trainer_ena, wr_ena, addr, wr_data), RAM read data in.
module nn_mem_arbiter
    import nn_mem_pkg::*;
#(
    parameter int ADDR_LEN     = NN_ADDR_LEN,
    parameter int DATA_LEN     = NN_DATA_LEN,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [1:0]            sel_i,
    input  logic [1:0]            last_i,
    input  logic [2*ADDR_LEN-1:0] addr_i,
    input  logic [2*DATA_LEN-1:0] wdata_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [DATA_LEN-1:0]   rdata_o,
    output logic                  lock_err_o,
    output logic                  network_ena_o,
    output logic                  trainer_ena_o,
    output logic                  wr_ena_o,
    output logic [ADDR_LEN-1:0]   addr_o,
    output logic [DATA_LEN-1:0]   wr_data_o,
    input  logic [DATA_LEN-1:0]   network_rd_data_i,
    input  logic [DATA_LEN-1:0]   trainer_rd_data_i
);

    localparam int                CNT_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_TIMEOUT);

    arb_state_t       state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             lock_err_d;
    logic [1:0]       gnt;
    logic             accept;
    logic             winner;
    mem_beat_t        beat0, beat1, beat_win;

    assign beat0 = '{we: we_i[0], sel: mem_sel_t'(sel_i[0]), last: last_i[0],
                     addr: addr_i[0 +: ADDR_LEN], wdata: wdata_i[0 +: DATA_LEN]};
    assign beat1 = '{we: we_i[1], sel: mem_sel_t'(sel_i[1]), last: last_i[1],
                     addr: addr_i[ADDR_LEN +: ADDR_LEN], wdata: wdata_i[DATA_LEN +: DATA_LEN]};

    always_comb begin
        gnt          = '0;
        state_d      = state_q;
        last_owner_d = last_owner_q;
        idle_cnt_d   = idle_cnt_q;
        lock_err_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (&req_i) gnt[~last_owner_q] = 1'b1;
                else        gnt = req_i;
            end
            ARB_LOCK0: gnt[0] = req_i[0];
            ARB_LOCK1: gnt[1] = req_i[1];
            default:   gnt = '0;
        endcase

        accept   = |gnt;
        winner   = gnt[1];
        beat_win = winner ? beat1 : beat0;

        if (accept) begin
            last_owner_d = winner;
            idle_cnt_d   = '0;
            state_d      = beat_win.last ? ARB_IDLE : lock_state(winner);
        end else if (state_q != ARB_IDLE) begin
            // No accept while locked means the owner is idle this cycle. An owner that
            // re-requests in the timeout cycle is accepted above, so no error then.
            if (idle_cnt_q == CNT_MAX) begin
                state_d    = ARB_IDLE;
                idle_cnt_d = '0;
                lock_err_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    assign gnt_o = gnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ARB_IDLE;
            last_owner_q  <= 1'b1;
            idle_cnt_q    <= '0;
            lock_err_o    <= 1'b0;
            network_ena_o <= 1'b0;
            trainer_ena_o <= 1'b0;
            wr_ena_o      <= 1'b0;
            addr_o        <= '0;
            wr_data_o     <= '0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            idle_cnt_q    <= idle_cnt_d;
            lock_err_o    <= lock_err_d;
            network_ena_o <= accept & (beat_win.sel == SEL_NETWORK);
            trainer_ena_o <= accept & (beat_win.sel == SEL_TRAINER);
            wr_ena_o      <= accept & beat_win.we;
            if (accept) begin
                addr_o    <= beat_win.addr;
                wr_data_o <= beat_win.wdata;
            end
        end
    end

    nn_mem_rd_pipe #(
        .DATA_LEN(DATA_LEN)
    ) u_rd_pipe (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .issue_i           (accept & ~beat_win.we),
        .owner_i           (winner),
        .sel_i             (beat_win.sel),
        .network_rd_data_i (network_rd_data_i),
        .trainer_rd_data_i (trainer_rd_data_i),
        .rvalid_o          (rvalid_o),
        .rdata_o           (rdata_o)
    );

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Directed bench for nn_mem_arbiter with behavioural RAMs, a golden memory and a read scoreboard.
module tb_nn_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0, we = '0, sel = '0, last = '0;
    logic [4:0]  addr_b [2];
    logic [31:0] wd_b   [2];

    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, wr_data, nrd, trd;
    logic        lock_err, nena, tena, wr_ena;
    logic [4:0]  addr;

    always #5 clk = ~clk;

    nn_mem_arbiter dut (
        .clk_i(clk), .reset_i(rst), .req_i(req), .we_i(we), .sel_i(sel), .last_i(last),
        .addr_i({addr_b[1], addr_b[0]}), .wdata_i({wd_b[1], wd_b[0]}),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .lock_err_o(lock_err),
        .network_ena_o(nena), .trainer_ena_o(tena), .wr_ena_o(wr_ena),
        .addr_o(addr), .wr_data_o(wr_data),
        .network_rd_data_i(nrd), .trainer_rd_data_i(trd)
    );

    // Power-on RAM contents are key(sel, addr); arrays store data XOR key so they start at zero.
    function automatic logic [31:0] key(input logic s, input logic [4:0] a);
        logic [31:0] base;
        base = s ? 32'h5A5A_0000 : 32'hA5A5_0000;
        return base | {19'd0, a, 3'd0, a};
    endfunction

    logic [31:0] nram [32] = '{default: 32'h0};
    logic [31:0] tram [32] = '{default: 32'h0};

    // Write-first synchronous RAMs, data valid the cycle after ena.
    always @(posedge clk) begin
        if (nena) begin
            if (wr_ena) nram[addr] <= wr_data ^ key(1'b0, addr);
            nrd <= wr_ena ? wr_data : (nram[addr] ^ key(1'b0, addr));
        end
        if (tena) begin
            if (wr_ena) tram[addr] <= wr_data ^ key(1'b1, addr);
            trd <= wr_ena ? wr_data : (tram[addr] ^ key(1'b1, addr));
        end
    end

    typedef struct {
        int          due;
        logic [1:0]  rv;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     rd_q [$];
    logic [31:0] gold [2][32];
    int          vectors = 0, miscompares = 0, cyc = 0;
    logic        e_nena = 0, e_tena = 0, e_wr = 0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0, e_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at negedge, record the accepted beat, step past posedge.
    task automatic tick(input logic [1:0] eg, input logic ee);
        logic [1:0] acc;
        int         w;
        rd_exp_t    e;
        @(negedge clk);
        chk("gnt", 64'(gnt), 64'(eg));
        chk("lock_err", 64'(lock_err), 64'(ee));
        chk("mem_issue", 64'({nena, tena, wr_ena, addr, wr_data}),
            64'({e_nena, e_tena, e_wr, e_addr, e_data}));
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e = rd_q.pop_front();
            e_rdata = e.data;
            chk("rvalid", 64'(rvalid), 64'(e.rv));
        end else begin
            chk("rvalid", 64'(rvalid), 64'd0);
        end
        chk("rdata", 64'(rdata), 64'(e_rdata));
        acc = eg & req;
        e_nena = 1'b0; e_tena = 1'b0; e_wr = 1'b0;
        if (acc != 2'b00) begin
            w = acc[1] ? 1 : 0;
            e_nena = ~sel[w];
            e_tena = sel[w];
            e_wr   = we[w];
            e_addr = addr_b[w];
            e_data = wd_b[w];
            if (we[w]) begin
                gold[sel[w]][addr_b[w]] = wd_b[w];
            end else begin
                e.due  = cyc + 2;
                e.rv   = acc;
                e.data = gold[sel[w]][addr_b[w]];
                rd_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_beat(input int r, input logic w, input logic s, input logic l,
                            input logic [4:0] a, input logic [31:0] d);
        req[r] = 1'b1; we[r] = w; sel[r] = s; last[r] = l; addr_b[r] = a; wd_b[r] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({gnt, rvalid, rdata, lock_err, nena, tena, wr_ena, addr, wr_data}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            gold[0][i] = key(1'b0, 5'(i));
            gold[1][i] = key(1'b1, 5'(i));
        end
        addr_b[0] = '0; addr_b[1] = '0; wd_b[0] = '0; wd_b[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        rst = 1'b0;

        // Both requesting single-beat reads: rr starts with requester 0.
        set_beat(0, 1'b0, 1'b0, 1'b1, 5'd1, '0);
        set_beat(1, 1'b0, 1'b1, 1'b1, 5'd4, '0);
        tick(2'b01, 1'b0); tick(2'b10, 1'b0); tick(2'b01, 1'b0); tick(2'b10, 1'b0);
        req = '0;
        tick(2'b00, 1'b0); tick(2'b00, 1'b0);

        // 4-beat write burst from 0 with 1 waiting; 1 then reads back the first burst word.
        set_beat(1, 1'b0, 1'b0, 1'b1, 5'd8, '0);
        for (int k = 0; k < 4; k++) begin
            set_beat(0, 1'b1, 1'b0, (k == 3), 5'(8 + k), 32'hC0DE_0000 + 32'(k));
            tick(2'b01, 1'b0);
        end
        req[0] = 1'b0;
        tick(2'b10, 1'b0);
        req = '0;
        tick(2'b00, 1'b0); tick(2'b00, 1'b0);

        // Single read from network RAM address 3.
        set_beat(0, 1'b0, 1'b0, 1'b1, 5'd3, '0);
        tick(2'b01, 1'b0);
        req = '0;
        tick(2'b00, 1'b0); tick(2'b00, 1'b0);

        // Trainer write then read-after-write of the same address.
        set_beat(0, 1'b1, 1'b1, 1'b1, 5'd2, 32'hDEAD_BEEF);
        tick(2'b01, 1'b0);
        set_beat(0, 1'b0, 1'b1, 1'b1, 5'd2, '0);
        tick(2'b01, 1'b0);
        req = '0;
        tick(2'b00, 1'b0); tick(2'b00, 1'b0);
        chk("raw_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

        // Lock timeout: 1 locks then goes idle; pending 0 is served after the forced release.
        set_beat(1, 1'b0, 1'b0, 1'b0, 5'd5, '0);
        tick(2'b10, 1'b0);
        req[1] = 1'b0;
        set_beat(0, 1'b0, 1'b0, 1'b1, 5'd6, '0);
        repeat (17) tick(2'b00, 1'b0);
        tick(2'b01, 1'b1);
        req = '0;
        tick(2'b00, 1'b0); tick(2'b00, 1'b0);

        // Owner re-requests in the timeout cycle: granted, no error, lock released by last.
        set_beat(1, 1'b0, 1'b1, 1'b0, 5'd9, '0);
        tick(2'b10, 1'b0);
        req[1] = 1'b0;
        repeat (16) tick(2'b00, 1'b0);
        set_beat(1, 1'b0, 1'b1, 1'b1, 5'd10, '0);
        tick(2'b10, 1'b0);
        req = '0;
        tick(2'b00, 1'b0);
        set_beat(0, 1'b0, 1'b0, 1'b1, 5'd31, '0);
        tick(2'b01, 1'b0);
        req = '0;
        tick(2'b00, 1'b0); tick(2'b00, 1'b0);

        // Reset one cycle after a read accept: in-flight read is dropped.
        set_beat(0, 1'b0, 1'b0, 1'b1, 5'd7, '0);
        tick(2'b01, 1'b0);
        req = '0;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        rd_q.delete();
        e_nena = 0; e_tena = 0; e_wr = 0; e_addr = '0; e_data = '0; e_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick(2'b00, 1'b0);
        chk("scoreboard_empty", 64'(rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
